memarb: RTL and testbench

Parametrised N-client arbiter that multiplexes DMA request ports (HDMI scanout, ADC capture, future clients) onto the single request port of the DDR controller `mem`. It holds each grant for a complete burst, request through last data beat, and forwards the controller's ack and ready strobes to the granted client. Selection is fixed-priority or round-robin, chosen at compile time.

---
 rtl/memarb_pkg.sv | 19 +
 rtl/memarb_if.sv | 38 +++
 rtl/memarb_pick.sv | 26 ++
 rtl/memarb.sv | 147 ++++++++++++++
 tb/tb_memarb.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memarb_pkg.sv
// Shared definitions for the memarb DDR request arbiter: bus widths and FSM encoding.
package memarb_pkg;

  localparam int MEM_AW   = 23;
  localparam int MEM_DW   = 32;
  localparam int MEM_LENW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Round-robin pointer width; a single-port build still needs a 1-bit vector.
  function automatic int ptr_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/memarb_if.sv
// Client-side and mem-side request bus of memarb, grouped for one port connection.
interface memarb_if
  import memarb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW
);

  logic [PORTS-1:0]          creq;
  logic [PORTS-1:0]          cwr;
  logic [MEM_LENW*PORTS-1:0] clen;
  logic [AW*PORTS-1:0]       caddr;
  logic [DW*PORTS-1:0]       cwdata;
  logic [PORTS-1:0]          cack;
  logic [PORTS-1:0]          cready;

  logic                      mreq;
  logic                      mwr;
  logic [MEM_LENW-1:0]       mlen;
  logic [AW-1:0]             maddr;
  logic [DW-1:0]             mwdata;
  logic                      mack;
  logic                      mready;

  // Arbiter view.
  modport master (
    input  creq, cwr, clen, caddr, cwdata, mack, mready,
    output cack, cready, mreq, mwr, mlen, maddr, mwdata
  );

  // Clients plus memory controller view.
  modport slave (
    output creq, cwr, clen, caddr, cwdata, mack, mready,
    input  cack, cready, mreq, mwr, mlen, maddr, mwdata
  );

endinterface

// File: rtl/memarb_pick.sv
// Combinational one-hot picker: lowest-index request at or after ptr, wrapping.
// With ptr tied to 0 it degenerates to fixed priority, port 0 highest.
module memarb_pick
  import memarb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int PW    = ptr_w(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PORTS-1:0] pick
);

  logic [2*PORTS-1:0] req_dbl;
  logic [PORTS-1:0]   rot;
  logic [PORTS-1:0]   rot_pick;
  logic [2*PORTS-1:0] back_dbl;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
  assign req_dbl  = {req, req} >> ptr;
  assign rot      = req_dbl[PORTS-1:0];
  assign rot_pick = rot & (-rot);
  assign back_dbl = {rot_pick, rot_pick} << ptr;
  assign pick     = back_dbl[2*PORTS-1:PORTS];

endmodule

// File: rtl/memarb.sv
// memarb: N-client burst arbiter onto the single DDR controller request port.
// Define MEMARB_RR_EN for round-robin selection (default: fixed priority); SIM enables the protocol assertion.
module memarb
  import memarb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW
) (
  input  logic             clk,
  input  logic             rstn,
  memarb_if.master         bus,
  output logic [PORTS-1:0] gnt
);

  localparam int PW = ptr_w(PORTS);

  state_t              state_reg, state_next;
  logic [PORTS-1:0]    gnt_reg, gnt_next;
  logic [MEM_LENW-1:0] beats_reg, beats_next;
  logic [PORTS-1:0]    pick;
  logic [PW-1:0]       pick_ptr;

  logic [AW-1:0]       addr_m  [PORTS];
  logic [DW-1:0]       wdata_m [PORTS];
  logic [MEM_LENW-1:0] len_m   [PORTS];
  logic [PORTS-1:0]    cack_v, cready_v;
  logic [AW-1:0]       maddr_sel;
  logic [DW-1:0]       mwdata_sel;
  logic [MEM_LENW-1:0] mlen_sel;

`ifdef MEMARB_RR_EN
  logic [PW-1:0] ptr_reg, ptr_next, pick_idx;

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < PORTS; i++)
      if (pick[i]) pick_idx = pick_idx | PW'(i);
  end

  // Next search starts one past the port just granted.
  always_comb begin
    ptr_next = ptr_reg;
    if (state_reg == IDLE && |bus.creq)
      ptr_next = (pick_idx == PW'(PORTS - 1)) ? '0 : pick_idx + PW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

  assign pick_ptr = ptr_reg;
`else
  assign pick_ptr = '0;
`endif

  memarb_pick #(.PORTS(PORTS), .PW(PW)) u_pick (
    .req  (bus.creq),
    .ptr  (pick_ptr),
    .pick (pick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      beats_reg <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      beats_reg <= beats_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    beats_next = beats_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.creq) begin
          gnt_next   = pick;
          state_next = REQ;
        end else begin
          gnt_next = '0;
        end
      end
      REQ: begin
        if (bus.mack) begin
          beats_next = mlen_sel;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bus.mready) begin
          if (beats_reg == '0) begin
            state_next = IDLE;
            gnt_next   = '0;
          end else begin
            beats_next = beats_reg - MEM_LENW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // Per-port gating by the grant; strobes only pass in the matching phase.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    assign addr_m[gi]   = bus.caddr[gi*AW +: AW] & {AW{gnt_reg[gi]}};
    assign wdata_m[gi]  = bus.cwdata[gi*DW +: DW] & {DW{gnt_reg[gi]}};
    assign len_m[gi]    = bus.clen[gi*MEM_LENW +: MEM_LENW] & {MEM_LENW{gnt_reg[gi]}};
    assign cack_v[gi]   = gnt_reg[gi] & bus.mack & (state_reg == REQ);
    assign cready_v[gi] = gnt_reg[gi] & bus.mready & (state_reg == DATA);
  end

  always_comb begin
    maddr_sel  = '0;
    mwdata_sel = '0;
    mlen_sel   = '0;
    for (int i = 0; i < PORTS; i++) begin
      maddr_sel  = maddr_sel | addr_m[i];
      mwdata_sel = mwdata_sel | wdata_m[i];
      mlen_sel   = mlen_sel | len_m[i];
    end
  end

  assign bus.mreq   = (state_reg == REQ);
  assign bus.mwr    = |(bus.cwr & gnt_reg);
  assign bus.mlen   = mlen_sel;
  assign bus.maddr  = maddr_sel;
  assign bus.mwdata = mwdata_sel;
  assign bus.cack   = cack_v;
  assign bus.cready = cready_v;
  assign gnt        = gnt_reg;

`ifdef SIM
  // A granted client must hold its request until it sees cack.
  a_creq_held: assert property (@(posedge clk) disable iff (!rstn)
    (state_reg == REQ) |-> |(bus.creq & gnt_reg));
`endif

endmodule

// File: tb/tb_memarb.sv
// Scoreboard bench for memarb: 4 clients, a small mem responder, expected bursts queued in grant order.
module tb_memarb;
  import memarb_pkg::*;

  localparam int P       = 4;
  localparam int AW      = MEM_AW;
  localparam int DW      = MEM_DW;
  localparam int ACK_LAT = 2;
`ifdef MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int            port;
    logic          wr;
    logic [1:0]    len;
    logic [AW-1:0] addr;
  } txn_t;

  logic         clk;
  logic         rstn;
  logic [P-1:0] gnt;

  memarb_if #(.PORTS(P), .AW(AW), .DW(DW)) bus ();

  memarb #(.PORTS(P), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .gnt  (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  txn_t exp_q[$];
  txn_t cur;

  logic          wr_c   [P];
  logic [1:0]    len_c  [P];
  logic [AW-1:0] addr_c [P];
  logic [DW-1:0] wbase  [P];
  int            req_cnt[P];
  int            bidx   [P];
  int            cack_cnt[P];
  int            crdy_cnt[P];

  int mphase, mcnt, mbeat, cyc, last_done_cyc, done_cnt, rst_after;
  bit stray_en, rst_pending;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [P-1:0] onehot(input int p);
    logic [P-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic set_client(input int p, input logic wr, input logic [1:0] len,
                            input logic [AW-1:0] addr, input int cnt);
    wr_c[p]    = wr;
    len_c[p]   = len;
    addr_c[p]  = addr;
    req_cnt[p] = cnt;
  endtask

  task automatic expect_burst(input int p);
    txn_t t;
    t.port = p;
    t.wr   = wr_c[p];
    t.len  = len_c[p];
    t.addr = addr_c[p];
    exp_q.push_back(t);
  endtask

  task automatic clear_counts();
    for (int p = 0; p < P; p++) begin
      cack_cnt[p] = 0;
      crdy_cnt[p] = 0;
    end
  endtask

  // One clock: drive clients and mem at negedge, sample 1 ns later, then advance models.
  task automatic tick();
    logic         do_ack, do_rdy, s_ack, s_rdy;
    logic [P-1:0] e_cack, e_crdy;
    @(negedge clk);
    cyc++;
    for (int p = 0; p < P; p++) begin
      bus.creq[p]            = (req_cnt[p] > 0);
      bus.cwr[p]             = wr_c[p];
      bus.clen[2*p +: 2]     = len_c[p];
      bus.caddr[AW*p +: AW]  = addr_c[p];
      bus.cwdata[DW*p +: DW] = wbase[p] + DW'(bidx[p]);
    end
    do_ack = 1'b0; do_rdy = 1'b0; s_ack = 1'b0; s_rdy = 1'b0;
    e_cack = '0;   e_crdy = '0;
    if (mphase == 0 && bus.mreq) begin
      chk("mreq_expected", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        cur    = exp_q.pop_front();
        mphase = 1;
        mcnt   = ACK_LAT;
        chk("turnaround", 64'((cyc - last_done_cyc) >= 2), 1);
      end
    end
    if (mphase == 1) begin
      chk("mreq_hold", bus.mreq, 1);
      chk("maddr", bus.maddr, cur.addr);
      chk("mwr", bus.mwr, cur.wr);
      chk("mlen", bus.mlen, cur.len);
      chk("gnt_req", gnt, onehot(cur.port));
      if (mcnt == 0) begin
        do_ack = 1'b1;
        e_cack = onehot(cur.port);
      end else begin
        mcnt--;
      end
      if (stray_en && !do_ack) s_rdy = 1'($urandom_range(0, 1));
    end else if (mphase == 2) begin
      chk("mreq_data", bus.mreq, 0);
      chk("gnt_data", gnt, onehot(cur.port));
      do_rdy = ($urandom_range(0, 3) != 0);
      if (do_rdy) e_crdy = onehot(cur.port);
      if (stray_en) s_ack = 1'($urandom_range(0, 1));
    end else begin
      chk("gnt_idle", gnt, 0);
      if (stray_en) s_rdy = 1'($urandom_range(0, 1));
    end
    bus.mack   = do_ack | s_ack;
    bus.mready = do_rdy | s_rdy;
    #1;
    chk("cack", bus.cack, e_cack);
    chk("cready", bus.cready, e_crdy);
    if (do_rdy) chk("mwdata", bus.mwdata, wbase[cur.port] + DW'(mbeat));
    for (int p = 0; p < P; p++) begin
      if (bus.cack[p]) begin
        if (req_cnt[p] > 0) req_cnt[p]--;
        bidx[p] = 0;
        cack_cnt[p]++;
      end
      if (bus.cready[p]) begin
        bidx[p]++;
        crdy_cnt[p]++;
      end
    end
    if (do_ack) begin
      mphase = 2;
      mbeat  = 0;
    end else if (do_rdy) begin
      mbeat++;
      if (mbeat == int'(cur.len) + 1) begin
        mphase        = 0;
        done_cnt++;
        last_done_cyc = cyc;
        $display("burst done: port=%0d wr=%0d beats=%0d addr=%06h cyc=%0d",
                 cur.port, cur.wr, mbeat, cur.addr, cyc);
      end else if (rst_after != 0 && mbeat == rst_after) begin
        rst_pending = 1'b1;
      end
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int start, k;
    start = done_cnt;
    k     = 0;
    while ((done_cnt - start) < n && k < budget) begin
      tick();
      k++;
    end
    chk("bursts_done", 64'(done_cnt - start), 64'(n));
  endtask

  task automatic chk_zero();
    chk("rz_mreq", bus.mreq, 0);
    chk("rz_mwr", bus.mwr, 0);
    chk("rz_mlen", bus.mlen, 0);
    chk("rz_maddr", bus.maddr, 0);
    chk("rz_mwdata", bus.mwdata, 0);
    chk("rz_cack", bus.cack, 0);
    chk("rz_cready", bus.cready, 0);
    chk("rz_gnt", gnt, 0);
  endtask

  initial begin
    int k;
    mphase = 0; mcnt = 0; mbeat = 0; cyc = 0; last_done_cyc = -10; done_cnt = 0;
    rst_after = 0; stray_en = 1'b0; rst_pending = 1'b0;
    for (int p = 0; p < P; p++) begin
      set_client(p, 1'b0, 2'd0, '0, 0);
      wbase[p] = 32'hA + DW'(p) * 32'h1000;
      bidx[p]  = 0;
    end
    clear_counts();

    // Reset state, with strobes and requests active to show they are masked.
    rstn       = 1'b0;
    bus.creq   = '1;
    bus.cwr    = '1;
    bus.clen   = '1;
    bus.caddr  = '1;
    bus.cwdata = '1;
    bus.mack   = 1'b1;
    bus.mready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_zero();
    bus.creq   = '0;
    bus.mack   = 1'b0;
    bus.mready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) tick();

    // Single read client on port 1, clen=3.
    clear_counts();
    set_client(1, 1'b0, 2'd3, 23'h000100, 1);
    expect_burst(1);
    tick();
    tick();
    chk("grant_lat", 64'(mphase), 1);
    run_until(1, 100);
    chk("cack1_cnt", 64'(cack_cnt[1]), 1);
    chk("cready1_cnt", 64'(crdy_cnt[1]), 4);
    chk("cack0_cnt", 64'(cack_cnt[0]), 0);
    chk("cready0_cnt", 64'(crdy_cnt[0]), 0);

    // Ports 0 and 1 request together, held for four bursts each.
    set_client(0, 1'b0, 2'd1, 23'h000200, 4);
    set_client(1, 1'b0, 2'd1, 23'h000300, 4);
    for (int i = 0; i < 8; i++)
      if (RR) expect_burst(i % 2);
      else    expect_burst(i / 4);
    run_until(8, 400);

    // Write burst on port 0: data 0xA, 0xB, 0xC.
    set_client(0, 1'b1, 2'd2, 23'h000040, 1);
    expect_burst(0);
    run_until(1, 100);

    // Stray mack during DATA and stray mready in IDLE/REQ.
    stray_en = 1'b1;
    set_client(1, 1'b0, 2'd3, 23'h001000, 1);
    expect_burst(1);
    run_until(1, 100);
    repeat (8) tick();
    stray_en = 1'b0;
    repeat (2) tick();

    // Reset after the 2nd of 4 beats on port 2, then ports 0 and 3 from IDLE.
    set_client(2, 1'b0, 2'd3, 23'h002000, 1);
    expect_burst(2);
    rst_after = 2;
    k = 0;
    while (!rst_pending && k < 100) begin
      tick();
      k++;
    end
    chk("rst_reached", 64'(rst_pending), 1);
    @(negedge clk);
    rstn       = 1'b0;
    req_cnt[2] = 0;
    bus.creq   = '0;
    bus.mack   = 1'b1;
    bus.mready = 1'b1;
    #1;
    chk_zero();
    @(negedge clk);
    bus.mack    = 1'b0;
    bus.mready  = 1'b0;
    rstn        = 1'b1;
    mphase      = 0;
    rst_after   = 0;
    rst_pending = 1'b0;
    set_client(0, 1'b0, 2'd0, 23'h003000, 1);
    set_client(3, 1'b0, 2'd1, 23'h004000, 1);
    expect_burst(0);
    expect_burst(3);
    run_until(2, 100);

    // All four ports requesting, two bursts each.
    for (int p = 0; p < P; p++)
      set_client(p, p[0], 2'(p), 23'h010000 + 23'(p * 16), 2);
    for (int i = 0; i < 8; i++)
      if (RR) expect_burst(i % 4);
      else    expect_burst(i / 2);
    run_until(8, 500);

    repeat (4) tick();
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
